ecdh_scalar_arbiter: RTL

ECDH_SCALAR_ARBITER -- requirements
Module: ecdh_scalar_arbiter

---
 rtl/ecdh_scalar_arbiter.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/ecdh_scalar_arbiter.sv
// Two-requester front end for a single ECDH scalar-multiplication engine.
// Arbitrates requests, launches the engine, watches for a hang, and returns the result or an abort.
module ecdh_scalar_arbiter #(
    parameter int unsigned BW      = 192,
    parameter int unsigned TIMEOUT = 2000000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic [BW-1:0] k0,
    input  logic [BW-1:0] k1,
    input  logic [BW-1:0] px0,
    input  logic [BW-1:0] px1,
    input  logic [BW-1:0] py0,
    input  logic [BW-1:0] py1,
    output logic          ack0,
    output logic          ack1,
    output logic          resp_valid,
    output logic          resp_id,
    output logic          resp_err,
    output logic [BW-1:0] resp_x,
    output logic [BW-1:0] resp_y,
    output logic          busy,
    output logic          eng_start,
    output logic          eng_rst_n,
    output logic [BW-1:0] eng_k,
    output logic [BW-1:0] eng_px,
    output logic [BW-1:0] eng_py,
    input  logic [BW-1:0] eng_qx,
    input  logic [BW-1:0] eng_qy,
    input  logic          eng_valid
);

    localparam int unsigned WDW = 21;
    localparam logic [WDW-1:0] WD_LIMIT = WDW'(TIMEOUT);
    localparam logic [WDW-1:0] WD_MAX   = '1;
    localparam logic [1:0]     HOLD_END = 2'd2;

    typedef enum logic [1:0] {INIT, IDLE, RUN, FLUSH} state_t;

    state_t         state, state_nxt;
    logic [1:0]     cnt, cnt_nxt;
    logic [WDW-1:0] wd, wd_nxt;
    logic           prio, prio_nxt;
    logic           cur_id, cur_id_nxt;
    logic           grant;
    logic           ack0_nxt, ack1_nxt, eng_start_nxt, eng_rst_n_nxt, busy_nxt;
    logic           resp_valid_nxt, resp_id_nxt, resp_err_nxt;
    logic [BW-1:0]  resp_x_nxt, resp_y_nxt;
    logic [BW-1:0]  eng_k_nxt, eng_px_nxt, eng_py_nxt;

    // Next-state and next-output logic; every output is registered from these.
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        wd_nxt         = wd;
        prio_nxt       = prio;
        cur_id_nxt     = cur_id;
        grant          = 1'b0;
        ack0_nxt       = 1'b0;
        ack1_nxt       = 1'b0;
        eng_start_nxt  = 1'b0;
        resp_valid_nxt = 1'b0;
        resp_id_nxt    = resp_id;
        resp_err_nxt   = resp_err;
        resp_x_nxt     = resp_x;
        resp_y_nxt     = resp_y;
        eng_k_nxt      = eng_k;
        eng_px_nxt     = eng_px;
        eng_py_nxt     = eng_py;

        case (state)
            INIT, FLUSH: begin
                if (cnt == HOLD_END) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 2'd0;
                end else begin
                    cnt_nxt = cnt + 2'd1;
                end
            end
            IDLE: begin
                if (req0 || req1) begin
                    grant         = (req0 && req1) ? prio : req1;
                    cur_id_nxt    = grant;
                    eng_k_nxt     = grant ? k1 : k0;
                    eng_px_nxt    = grant ? px1 : px0;
                    eng_py_nxt    = grant ? py1 : py0;
                    ack0_nxt      = ~grant;
                    ack1_nxt      = grant;
                    eng_start_nxt = 1'b1;
                    wd_nxt        = '0;
                    state_nxt     = RUN;
                end
            end
            RUN: begin
                wd_nxt = (wd == WD_MAX) ? wd : wd + WDW'(1);
                // wd counts cycles since the start pulse; the start cycle itself is outside the window.
                if (eng_valid && (wd != '0)) begin
                    resp_valid_nxt = 1'b1;
                    resp_err_nxt   = 1'b0;
                    resp_id_nxt    = cur_id;
                    resp_x_nxt     = eng_qx;
                    resp_y_nxt     = eng_qy;
                    prio_nxt       = ~cur_id;
                    state_nxt      = IDLE;
                end else if (wd >= WD_LIMIT) begin
                    resp_valid_nxt = 1'b1;
                    resp_err_nxt   = 1'b1;
                    resp_id_nxt    = cur_id;
                    resp_x_nxt     = '0;
                    resp_y_nxt     = '0;
                    prio_nxt       = ~cur_id;
                    cnt_nxt        = 2'd1;
                    state_nxt      = FLUSH;
                end
            end
            default: state_nxt = INIT;
        endcase

        eng_rst_n_nxt = (state_nxt != INIT) && (state_nxt != FLUSH);
        busy_nxt      = (state_nxt != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= INIT;
            cnt        <= 2'd0;
            wd         <= '0;
            prio       <= 1'b0;
            cur_id     <= 1'b0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            eng_start  <= 1'b0;
            eng_rst_n  <= 1'b0;
            busy       <= 1'b1;
            resp_valid <= 1'b0;
            resp_id    <= 1'b0;
            resp_err   <= 1'b0;
            resp_x     <= '0;
            resp_y     <= '0;
            eng_k      <= '0;
            eng_px     <= '0;
            eng_py     <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            wd         <= wd_nxt;
            prio       <= prio_nxt;
            cur_id     <= cur_id_nxt;
            ack0       <= ack0_nxt;
            ack1       <= ack1_nxt;
            eng_start  <= eng_start_nxt;
            eng_rst_n  <= eng_rst_n_nxt;
            busy       <= busy_nxt;
            resp_valid <= resp_valid_nxt;
            resp_id    <= resp_id_nxt;
            resp_err   <= resp_err_nxt;
            resp_x     <= resp_x_nxt;
            resp_y     <= resp_y_nxt;
            eng_k      <= eng_k_nxt;
            eng_px     <= eng_px_nxt;
            eng_py     <= eng_py_nxt;
        end
    end

endmodule
